// File: rtl/mem_controller_pkg.sv
// Shared definitions for the LSU-facing memory controller: controller states
// and default bus geometry.
package mem_controller_pkg;

    localparam int DEFAULT_ADDR_BITS     = 8;
    localparam int DEFAULT_DATA_BITS     = 8;
    localparam int DEFAULT_NUM_CONSUMERS = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } ctrl_state_t;

endpackage

// File: rtl/mem_controller_rr_arbiter.sv
// Combinational round-robin pick: first requesting consumer at or after
// rr_pointer, wrapping modulo NUM_CONSUMERS.
module mem_controller_rr_arbiter
    import mem_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = DEFAULT_NUM_CONSUMERS,
    parameter int IDX_BITS      = $clog2(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] request,
    input  logic [IDX_BITS-1:0]      rr_pointer,
    output logic [IDX_BITS-1:0]      grant_index,
    output logic                     grant_found
);

    logic [IDX_BITS-1:0] candidate;

    // NUM_CONSUMERS is a power of two, so truncating the sum is the wrap.
    always_comb begin
        grant_index = '0;
        grant_found = 1'b0;
        candidate   = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            candidate = rr_pointer + IDX_BITS'(i);
            if (!grant_found && request[candidate]) begin
                grant_found = 1'b1;
                grant_index = candidate;
            end
        end
    end

endmodule

// File: rtl/mem_controller.sv
// Serves LSU load/store requests over one shared data-memory port, one
// transaction at a time, with round-robin arbitration and a four-phase return.
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = DEFAULT_NUM_CONSUMERS
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                           mem_read_valid,
    output logic [ADDR_BITS-1:0]           mem_read_address,
    input  logic                           mem_read_ready,
    input  logic [DATA_BITS-1:0]           mem_read_data,
    output logic                           mem_write_valid,
    output logic [ADDR_BITS-1:0]           mem_write_address,
    output logic [DATA_BITS-1:0]           mem_write_data,
    input  logic                           mem_write_ready
);

    localparam int IDX_BITS = $clog2(NUM_CONSUMERS);

    ctrl_state_t state_reg, state_next;
    logic [IDX_BITS-1:0]      rr_pointer_reg, rr_pointer_next;
    logic [IDX_BITS-1:0]      grant_reg, grant_next;
    logic                     mem_read_valid_reg, mem_read_valid_next;
    logic                     mem_write_valid_reg, mem_write_valid_next;
    logic [ADDR_BITS-1:0]     mem_read_address_reg, mem_read_address_next;
    logic [ADDR_BITS-1:0]     mem_write_address_reg, mem_write_address_next;
    logic [DATA_BITS-1:0]     mem_write_data_reg, mem_write_data_next;
    logic [NUM_CONSUMERS-1:0] read_ready_reg, read_ready_next;
    logic [NUM_CONSUMERS-1:0] write_ready_reg, write_ready_next;

    logic [ADDR_BITS-1:0] read_addr  [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] write_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] write_data [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] read_data_reg [NUM_CONSUMERS];

    logic [IDX_BITS-1:0] arb_index;
    logic                arb_found;

    mem_controller_rr_arbiter #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .IDX_BITS      (IDX_BITS)
    ) u_arbiter (
        .request     (consumer_read_valid | consumer_write_valid),
        .rr_pointer  (rr_pointer_reg),
        .grant_index (arb_index),
        .grant_found (arb_found)
    );

    // Per-consumer unpacking, plus a load-data register that survives the
    // handshake so the LSU can still read it after ready drops.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_consumer
            assign read_addr[gi]  = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
            assign write_addr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
            assign write_data[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
            assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = read_data_reg[gi];

            always_ff @(posedge clock) begin
                if (reset) begin
                    read_data_reg[gi] <= '0;
                end else if (state_reg == READ_WAITING && mem_read_ready &&
                             grant_reg == IDX_BITS'(gi)) begin
                    read_data_reg[gi] <= mem_read_data;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next             = state_reg;
        rr_pointer_next        = rr_pointer_reg;
        grant_next             = grant_reg;
        mem_read_valid_next    = mem_read_valid_reg;
        mem_write_valid_next   = mem_write_valid_reg;
        mem_read_address_next  = mem_read_address_reg;
        mem_write_address_next = mem_write_address_reg;
        mem_write_data_next    = mem_write_data_reg;
        read_ready_next        = read_ready_reg;
        write_ready_next       = write_ready_reg;

        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    grant_next      = arb_index;
                    rr_pointer_next = arb_index + IDX_BITS'(1);
                    // A consumer asserting both gets its load first.
                    if (consumer_read_valid[arb_index]) begin
                        mem_read_valid_next   = 1'b1;
                        mem_read_address_next = read_addr[arb_index];
                        state_next            = READ_WAITING;
                    end else begin
                        mem_write_valid_next   = 1'b1;
                        mem_write_address_next = write_addr[arb_index];
                        mem_write_data_next    = write_data[arb_index];
                        state_next             = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    mem_read_valid_next        = 1'b0;
                    read_ready_next[grant_reg] = 1'b1;
                    state_next                 = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mem_write_valid_next        = 1'b0;
                    write_ready_next[grant_reg] = 1'b1;
                    state_next                  = WRITE_RELAYING;
                end
            end
            READ_RELAYING: begin
                if (!consumer_read_valid[grant_reg]) begin
                    read_ready_next = '0;
                    state_next      = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!consumer_write_valid[grant_reg]) begin
                    write_ready_next = '0;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg             <= IDLE;
            rr_pointer_reg        <= '0;
            grant_reg             <= '0;
            mem_read_valid_reg    <= 1'b0;
            mem_write_valid_reg   <= 1'b0;
            mem_read_address_reg  <= '0;
            mem_write_address_reg <= '0;
            mem_write_data_reg    <= '0;
            read_ready_reg        <= '0;
            write_ready_reg       <= '0;
        end else begin
            state_reg             <= state_next;
            rr_pointer_reg        <= rr_pointer_next;
            grant_reg             <= grant_next;
            mem_read_valid_reg    <= mem_read_valid_next;
            mem_write_valid_reg   <= mem_write_valid_next;
            mem_read_address_reg  <= mem_read_address_next;
            mem_write_address_reg <= mem_write_address_next;
            mem_write_data_reg    <= mem_write_data_next;
            read_ready_reg        <= read_ready_next;
            write_ready_reg       <= write_ready_next;
        end
    end

    assign mem_read_valid       = mem_read_valid_reg;
    assign mem_read_address     = mem_read_address_reg;
    assign mem_write_valid      = mem_write_valid_reg;
    assign mem_write_address    = mem_write_address_reg;
    assign mem_write_data       = mem_write_data_reg;
    assign consumer_read_ready  = read_ready_reg;
    assign consumer_write_ready = write_ready_reg;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed scenarios with literal expectations, then
// randomized LSU/memory traffic checked every cycle against a transaction model.
module tb_mem_controller;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int N  = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    crv = '0, cwv = '0;
    logic [N*AB-1:0] craddr = '0, cwaddr = '0;
    logic [N*DB-1:0] cwdata = '0;
    logic [N-1:0]    crr, cwr;
    logic [N*DB-1:0] crdata;
    logic            mrv, mwv;
    logic [AB-1:0]   mra, mwa;
    logic [DB-1:0]   mwd;
    logic            mrr = 1'b0, mwr = 1'b0;
    logic [DB-1:0]   mrd = '0;

    int tests_run    = 0;
    int tests_failed = 0;
    int served[$];

    mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .consumer_read_valid    (crv),
        .consumer_read_address  (craddr),
        .consumer_read_ready    (crr),
        .consumer_read_data     (crdata),
        .consumer_write_valid   (cwv),
        .consumer_write_address (cwaddr),
        .consumer_write_data    (cwdata),
        .consumer_write_ready   (cwr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding transaction described by who owns it, its direction and
    // whether memory has answered; outputs follow from those facts.
    bit              m_busy = 0, m_is_read = 0, m_answered = 0;
    int              m_grant = 0, m_ptr = 0, m_pick;
    logic [N-1:0]    m_req;
    logic            exp_mrv = 0, exp_mwv = 0;
    logic [AB-1:0]   exp_mra = '0, exp_mwa = '0;
    logic [DB-1:0]   exp_mwd = '0;
    logic [N-1:0]    exp_rr = '0, exp_wr = '0;
    logic [DB-1:0]   exp_rdata [N] = '{default: '0};
    int              waits [N] = '{default: 0};

    always @(negedge clock) begin
        check("mem_read_valid", mrv, exp_mrv);
        check("mem_write_valid", mwv, exp_mwv);
        check("mem_read_address", mra, exp_mra);
        check("mem_write_address", mwa, exp_mwa);
        check("mem_write_data", mwd, exp_mwd);
        for (int i = 0; i < N; i++) begin
            check($sformatf("read_ready[%0d]", i), crr[i], exp_rr[i]);
            check($sformatf("write_ready[%0d]", i), cwr[i], exp_wr[i]);
            check($sformatf("read_data[%0d]", i), crdata[i*DB +: DB], exp_rdata[i]);
        end

        if (reset) begin
            m_busy = 0; m_answered = 0; m_ptr = 0; m_grant = 0;
            exp_mrv = 0; exp_mwv = 0; exp_mra = '0; exp_mwa = '0; exp_mwd = '0;
            exp_rr = '0; exp_wr = '0;
            for (int i = 0; i < N; i++) begin
                exp_rdata[i] = '0;
                waits[i] = 0;
            end
        end else if (!m_busy) begin
            m_req  = crv | cwv;
            m_pick = -1;
            for (int k = 0; k < N; k++)
                if (m_pick < 0 && m_req[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
            if (m_pick >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (i != m_pick && m_req[i]) begin
                        waits[i]++;
                        check($sformatf("fairness[%0d]", i), (waits[i] < N) ? 1 : 0, 1);
                    end
                end
                waits[m_pick] = 0;
                m_busy = 1; m_answered = 0; m_grant = m_pick;
                m_ptr = (m_pick + 1) % N;
                m_is_read = crv[m_pick];
                if (m_is_read) begin
                    exp_mrv = 1;
                    exp_mra = craddr[m_pick*AB +: AB];
                end else begin
                    exp_mwv = 1;
                    exp_mwa = cwaddr[m_pick*AB +: AB];
                    exp_mwd = cwdata[m_pick*DB +: DB];
                end
            end
        end else if (!m_answered) begin
            if (m_is_read && mrr) begin
                exp_mrv = 0; exp_rr[m_grant] = 1; exp_rdata[m_grant] = mrd; m_answered = 1;
            end else if (!m_is_read && mwr) begin
                exp_mwv = 0; exp_wr[m_grant] = 1; m_answered = 1;
            end
        end else if (m_is_read ? !crv[m_grant] : !cwv[m_grant]) begin
            exp_rr = '0; exp_wr = '0; m_busy = 0;
        end
    end

    // Memory answers immediately; each LSU drops its valid once served.
    task automatic run_until(input int count);
        served.delete();
        for (int cyc = 0; cyc < 100 && served.size() < count; cyc++) begin
            mrd = mra ^ 8'hFF;
            tick();
            for (int i = 0; i < N; i++) begin
                if (crr[i] && crv[i]) begin served.push_back(i); crv[i] = 1'b0; end
                if (cwr[i] && cwv[i]) begin served.push_back(100 + i); cwv[i] = 1'b0; end
            end
        end
        check("served_count", served.size(), count);
        repeat (2) tick();
    endtask

    task automatic check_served(input string name, input int k, input int expected);
        check(name, (k < served.size()) ? served[k] : -1, expected);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bit all_idle;
        repeat (3) tick();
        check("reset_mem_read_valid", mrv, 0);
        check("reset_mem_write_valid", mwv, 0);
        check("reset_readies", {crr, cwr}, 0);
        reset = 1'b0;

        // single read, memory answers two cycles after valid
        crv[2] = 1'b1; craddr[2*AB +: AB] = 8'h3C;
        tick();
        check("t1_mem_read_valid", mrv, 1);
        check("t1_mem_read_address", mra, 8'h3C);
        tick();
        check("t1_valid_held", mrv, 1);
        mrr = 1'b1; mrd = 8'hA5;
        tick();
        mrr = 1'b0; mrd = 8'h00;
        check("t1_read_ready", crr, 4'b0100);
        check("t1_read_data", crdata[2*DB +: DB], 8'hA5);
        check("t1_mem_valid_drop", mrv, 0);
        crv[2] = 1'b0;
        tick();
        check("t1_ready_drop", crr, 0);
        check("t1_data_kept", crdata[2*DB +: DB], 8'hA5);
        $display("[TB] single read done");

        // single write, memory ready held high
        cwv[0] = 1'b1; cwaddr[0 +: AB] = 8'h10; cwdata[0 +: DB] = 8'h7E; mwr = 1'b1;
        tick();
        check("t2_mem_write_valid", mwv, 1);
        check("t2_mem_write_address", mwa, 8'h10);
        check("t2_mem_write_data", mwd, 8'h7E);
        check("t2_no_read", mrv, 0);
        tick();
        check("t2_write_ready", cwr, 4'b0001);
        check("t2_write_valid_drop", mwv, 0);
        cwv[0] = 1'b0; mwr = 1'b0;
        tick();
        check("t2_write_ready_drop", cwr, 0);
        $display("[TB] single write done");

        // round robin from a fresh pointer, then wrap
        do_reset();
        mrr = 1'b1; mwr = 1'b1;
        for (int i = 0; i < N; i++) begin
            crv[i] = 1'b1; craddr[i*AB +: AB] = 8'(17 * i);
        end
        run_until(4);
        for (int k = 0; k < 4; k++) check($sformatf("t3_order[%0d]", k), (k < served.size()) ? served[k] : -1, k);
        check("t3_data3", crdata[3*DB +: DB], 8'hCC);
        crv[0] = 1'b1; crv[3] = 1'b1;
        run_until(2);
        check_served("t3_wrap_first", 0, 0);
        check_served("t3_wrap_second", 1, 3);
        $display("[TB] round robin done");

        // read beats write from the same consumer
        crv[1] = 1'b1; craddr[1*AB +: AB] = 8'h21;
        cwv[1] = 1'b1; cwaddr[1*AB +: AB] = 8'h22; cwdata[1*DB +: DB] = 8'h5A;
        run_until(2);
        check_served("t4_read_first", 0, 1);
        check_served("t4_write_second", 1, 101);
        $display("[TB] read/write priority done");

        // reset while waiting on memory, then pointer back at consumer 0
        mrr = 1'b0; mwr = 1'b0;
        crv[1] = 1'b1; craddr[1*AB +: AB] = 8'h44;
        tick();
        check("t5_granted", mrv, 1);
        reset = 1'b1;
        tick();
        check("t5_mrv_zero", mrv, 0);
        check("t5_addr_zero", mra, 0);
        check("t5_readies_zero", {crr, cwr}, 0);
        reset = 1'b0; crv[1] = 1'b0;
        crv[0] = 1'b1; craddr[0 +: AB] = 8'h20;
        crv[3] = 1'b1; craddr[3*AB +: AB] = 8'h33;
        tick();
        check("t5_fresh_grant_addr", mra, 8'h20);
        mrr = 1'b1; mwr = 1'b1;
        run_until(2);
        check_served("t5_first", 0, 0);
        check_served("t5_second", 1, 3);
        $display("[TB] reset mid-transaction done");

        // memory stalls for 20 cycles with another consumer waiting
        do_reset();
        mrr = 1'b0; mwr = 1'b0;
        crv[2] = 1'b1; craddr[2*AB +: AB] = 8'h55;
        tick();
        cwv[0] = 1'b1; cwaddr[0 +: AB] = 8'h66; cwdata[0 +: DB] = 8'h99;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t6_valid_stable", mrv, 1);
            check("t6_addr_stable", mra, 8'h55);
            check("t6_no_write", mwv, 0);
            check("t6_no_ready", {crr, cwr}, 0);
        end
        mrr = 1'b1; mwr = 1'b1;
        run_until(2);
        check_served("t6_read_served", 0, 2);
        check_served("t6_write_served", 1, 100);
        $display("[TB] stalled memory done");

        // randomized traffic; the negedge model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(499) == 0);
            mrr = ($urandom_range(2) == 0);
            mwr = ($urandom_range(2) == 0);
            mrd = 8'($urandom);
            for (int i = 0; i < N; i++) begin
                if (crv[i] && crr[i]) crv[i] = 1'b0;
                else if (!crv[i] && !crr[i] && $urandom_range(7) == 0) begin
                    crv[i] = 1'b1; craddr[i*AB +: AB] = 8'($urandom);
                end
                if (cwv[i] && cwr[i]) cwv[i] = 1'b0;
                else if (!cwv[i] && !cwr[i] && $urandom_range(7) == 0) begin
                    cwv[i] = 1'b1; cwaddr[i*AB +: AB] = 8'($urandom); cwdata[i*DB +: DB] = 8'($urandom);
                end
            end
        end
        reset = 1'b0; mrr = 1'b1; mwr = 1'b1;
        all_idle = 0;
        for (int c = 0; c < 300 && !all_idle; c++) begin
            mrd = 8'($urandom);
            tick();
            for (int i = 0; i < N; i++) begin
                if (crv[i] && crr[i]) crv[i] = 1'b0;
                if (cwv[i] && cwr[i]) cwv[i] = 1'b0;
            end
            all_idle = ((crv | cwv | crr | cwr) == '0);
        end
        check("drain_idle", all_idle, 1);
        $display("[TB] random traffic done");

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Responder end of the LSU memory protocol: serves load/store requests from NUM_CONSUMERS LSUs over one shared external data-memory port.
- Arbitrates consumers round-robin, drives one memory transaction at a time, and returns read data or write-acknowledge to the granted LSU with a four-phase valid/ready handshake.
- Sits between the per-thread LSUs of all cores and the data memory.

Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 8, memory data width
- NUM_CONSUMERS, 4, number of LSUs served; power of two, ≥ 2

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- consumer_read_valid  in  NUM_CONSUMERS  per-LSU load request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  flattened load addresses; consumer i at [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  per-LSU load-data-valid
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  flattened load data
- consumer_write_valid  in  NUM_CONSUMERS  per-LSU store request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  flattened store addresses
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  flattened store data
- consumer_write_ready  out  NUM_CONSUMERS  per-LSU store-done
- mem_read_valid  out  1  read request to memory
- mem_read_address  out  ADDR_BITS  read address
- mem_read_ready  in  1  memory read data valid
- mem_read_data  in  DATA_BITS  memory read data
- mem_write_valid  out  1  write request to memory
- mem_write_address  out  ADDR_BITS  write address
- mem_write_data  out  DATA_BITS  write data
- mem_write_ready  in  1  memory write done

Behaviour:
- Reset: every output is 0, state IDLE, rr_pointer 0. Reset mid-transaction aborts immediately: the memory valid and all consumer readies drop the next edge.
- States:
  - IDLE: each cycle, scan consumers starting at rr_pointer, wrapping modulo NUM_CONSUMERS. The first consumer with read_valid or write_valid is granted. If both are set for one consumer, read wins.
    - Read grant: next edge latches address into mem_read_address, mem_read_valid=1, state READ_WAITING.
    - Write grant: latches address and data, mem_write_valid=1, state WRITE_WAITING.
    - Record grant index; rr_pointer = grant+1 (wraps from NUM_CONSUMERS-1 to 0).
  - READ_WAITING: hold address and valid. On mem_read_ready=1 the next edge does:
    - mem_read_valid=0
    - consumer_read_data[grant] = mem_read_data
    - consumer_read_ready[grant]=1
    - state READ_RELAYING
  - WRITE_WAITING: on mem_write_ready=1 the next edge does mem_write_valid=0, consumer_write_ready[grant]=1, state WRITE_RELAYING.
  - READ_RELAYING / WRITE_RELAYING: hold ready (and data) until the granted consumer's matching valid is sampled 0. The next edge clears ready and returns to IDLE. consumer_read_data[grant] keeps its value after ready drops.
- Minimum latency, request seen to consumer ready high, with memory ready in the first waiting cycle: 2 cycles. A new grant cannot occur in the cycle ready drops. Back-to-back transactions are spaced ≥ 4 cycles.
- No starvation: a waiting consumer is granted within NUM_CONSUMERS transactions.
- Requests that arrive while busy are not lost; they are held by the LSU's valid.
- A valid withdrawn before its grant is simply not seen.
- Only the granted consumer's ready can be high; at most one of mem_read_valid / mem_write_valid is high.
- Memory ready arriving while no request is outstanding is ignored.

Decomposition:
- Shared package/include: state encodings (IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING), defaults for ADDR_BITS/DATA_BITS.
- One sub-module: rr_arbiter (combinational round-robin priority pick). Inputs: request vector = read_valid|write_valid and rr_pointer. Outputs: grant index and grant_found.

Test Plan:
1. Single read: consumer 2 read_valid, addr 0x3C; memory returns 0xA5 two cycles after mem_read_valid -> mem_read_address=0x3C; consumer_read_ready[2]=1 with data 0xA5; ready drops one cycle after valid drops.
2. Single write: consumer 0 writes 0x7E to 0x10; mem_write_ready held high immediately -> mem_write_address=0x10, data=0x7E; consumer_write_ready[0] pulses per handshake; no read port activity.
3. Round-robin: all 4 consumers request reads at once, memory ready immediate -> grant order 0,1,2,3. Then consumers 0 and 3 re-request -> 0 served next (pointer wrapped).
4. Read/write priority: consumer 1 asserts both read and write -> read served first, write served on the following grant.
5. Reset mid-READ_WAITING -> next edge all outputs 0, state IDLE. A fresh request afterwards is served from consumer 0 priority.
6. Stalled memory: mem_read_ready withheld 20 cycles -> address and valid stable for the full stall; no other consumer granted.
